// File: rtl/wide_add_seq_if.sv
// Request/result bus of the sequential wide adder: valid/ready request side
// carrying the operands, valid/ready result side carrying sum and carry-out.
interface wide_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  // Requester / result consumer side.
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/wide_add_seq.sv
// Wide adder that reuses one 16-bit add-with-carry slice, one slice per clock,
// LSB slice first, with the carry chained through a flop between slices.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high; last result held on sum/c_out
// RUN   | adding slice idx of the latched operands, one slice per edge
// DONE  | result valid; held until the consumer takes it
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  wide_add_seq_if.slave bus
);
  // idx needs at least one bit even when there is only a single slice.
  localparam int            IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   c_out_q, c_out_d;
  logic [WORDS-1:0][15:0] a_q, a_d;
  logic [WORDS-1:0][15:0] b_q, b_d;
  logic [WORDS-1:0][15:0] sum_q, sum_d;
  logic [16:0]            slice_res;

  // The single 16-bit slice adder: current slice of A and B plus chained carry.
  always_comb begin
    slice_res = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {16'b0, carry_q};
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = slice_res[15:0];
        carry_d      = slice_res[16];
        if (idx_q == LAST) begin
          c_out_d = slice_res[16];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also drops any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // Handshake outputs are decoded from state only, never from the inputs.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
endmodule
